// File: rtl/instr_compressor.sv
// Pair-dictionary instruction compressor: folds adjacent word pairs found in a writable
// dictionary into token words. Statistics counters are built only when CMP_STATS_EN is defined.
module instr_compressor #(
  parameter int                       WIDTH         = 32,
  parameter logic [WIDTH-1:0]         PCADD         = 32'b100,
  parameter int                       ENCODE_LENGTH = 4,
  parameter logic [ENCODE_LENGTH-1:0] OPCODE        = 4'b1111,
  parameter int                       ENTRIES       = 16,
  parameter int                       IDX_W         = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_tgt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_addr,
  input  logic             wme,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] WriteData,
  output logic             collide,
  output logic [15:0]      raw_cnt,
  output logic [15:0]      tok_cnt,
  output logic             state_dbg
);

  typedef enum logic {EMPTY, HELD} state_t;

  localparam logic [WIDTH-1:0] TOK_BASE = {OPCODE, {(WIDTH-ENCODE_LENGTH){1'b0}}};

  state_t             state;
  logic [WIDTH-1:0]   hold;
  logic [WIDTH-1:0]   dict_first  [ENTRIES];
  logic [WIDTH-1:0]   dict_second [ENTRIES];
  logic [ENTRIES-1:0] dict_valid;

  logic             accept, do_flush, emit_tok, emit_raw, match_hit;
  logic [IDX_W-1:0] match_idx;
  logic [WIDTH-1:0] tok_word;

  // Handshake: a word moves on either side only in a cycle where valid && ready are both high;
  // a new output may be loaded whenever the output register is empty or being drained.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign do_flush  = flush && !accept && (state == HELD) && in_ready;
  assign state_dbg = (state == HELD);
  assign tok_word  = TOK_BASE | (WIDTH'(match_idx) * (PCADD << 1));

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (dict_valid[i] && dict_first[i] == hold && dict_second[i] == in_data) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    emit_tok = 1'b0;
    emit_raw = 1'b0;
    if (accept && state == HELD) begin
      if (!in_tgt && match_hit) emit_tok = 1'b1;
      else                      emit_raw = 1'b1;
    end else if (do_flush) begin
      emit_raw = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      collide   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_addr  <= out_addr + PCADD;
      end
      if (emit_tok) begin
        out_valid <= 1'b1;
        out_data  <= tok_word;
      end else if (emit_raw) begin
        out_valid <= 1'b1;
        out_data  <= hold;
        if (hold[WIDTH-1 -: ENCODE_LENGTH] == OPCODE) collide <= 1'b1;
      end
      if (accept) begin
        hold  <= in_data;
        state <= emit_tok ? EMPTY : HELD;
      end else if (do_flush) begin
        state <= EMPTY;
      end
    end
  end

  // Pair data is not reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (wme) begin
      if (wr_sel) dict_second[wr_idx] <= WriteData;
      else        dict_first[wr_idx]  <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)   dict_valid         <= '0;
    else if (wme) dict_valid[wr_idx] <= wr_sel;
  end

`ifdef CMP_STATS_EN
  logic        out_tok;
  logic [15:0] raw_q, tok_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_tok <= 1'b0;
      raw_q   <= '0;
      tok_q   <= '0;
    end else begin
      if (emit_tok)      out_tok <= 1'b1;
      else if (emit_raw) out_tok <= 1'b0;
      if (out_valid && out_ready) begin
        if (out_tok) begin
          if (tok_q != 16'hFFFF) tok_q <= tok_q + 16'd1;
        end else begin
          if (raw_q != 16'hFFFF) raw_q <= raw_q + 16'd1;
        end
      end
    end
  end

  assign raw_cnt = raw_q;
  assign tok_cnt = tok_q;
`else
  assign raw_cnt = '0;
  assign tok_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_compressor.sv
// Bench for instr_compressor: directed test-plan scenarios plus randomized traffic, all
// checked each cycle against a dictionary/queue reference model.
module tb_instr_compressor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_tgt, flush, out_ready, wme, wr_sel;
  logic         in_ready, out_valid, collide, state_dbg;
  logic [W-1:0] in_data, out_data, out_addr, WriteData;
  logic [3:0]   wr_idx;
  logic [15:0]  raw_cnt, tok_cnt;

  int checks = 0;
  int errors = 0;
  bit rand_oready = 0;
  bit started = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  bit           exp_tok[$];
  logic [W-1:0] m_first[16], m_second[16];
  bit           m_valid[16];
  bit           m_held, m_collide;
  logic [W-1:0] m_h, m_addr;
  logic [15:0]  m_raw, m_tok;
  logic [W-1:0] got_data[$], got_addr[$];

  instr_compressor dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tgt(in_tgt), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .wme(wme), .wr_idx(wr_idx), .wr_sel(wr_sel),
    .WriteData(WriteData), .collide(collide), .raw_cnt(raw_cnt), .tok_cnt(tok_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_first[i] == a && m_second[i] == b) return i;
    return -1;
  endfunction

  function automatic void push_word(input logic [W-1:0] d, input bit tok);
    exp_q.push_back(d);
    exp_tok.push_back(tok);
    if (!tok && d[31:28] == 4'hF) m_collide = 1;
  endfunction

  // Compare current outputs, then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    bit slot_free, acc, t;
    int idx;
    logic [W-1:0] d;
    if (started) begin
      chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      chk("out_addr", out_addr, m_addr);
      chk("collide", W'(collide), W'(m_collide));
      chk("in_ready", W'(in_ready), W'(exp_q.size() == 0 || out_ready));
      chk("held", W'(state_dbg), W'(m_held));
`ifdef CMP_STATS_EN
      chk("raw_cnt", W'(raw_cnt), W'(m_raw));
      chk("tok_cnt", W'(tok_cnt), W'(m_tok));
`else
      chk("raw_cnt", W'(raw_cnt), '0);
      chk("tok_cnt", W'(tok_cnt), '0);
`endif
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_addr.push_back(out_addr);
      end
    end
    if (!reset) begin
      started = 1;
      m_held = 0; m_collide = 0; m_addr = '0; m_raw = '0; m_tok = '0;
      exp_q.delete(); exp_tok.delete();
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (started) begin
      slot_free = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) begin
        d = exp_q.pop_front();
        t = exp_tok.pop_front();
        m_addr = m_addr + 32'd4;
        if (t) begin if (m_tok != 16'hFFFF) m_tok++; end
        else   begin if (m_raw != 16'hFFFF) m_raw++; end
      end
      acc = in_valid && slot_free;
      if (acc) begin
        if (!m_held) begin
          m_held = 1; m_h = in_data;
        end else begin
          idx = lookup(m_h, in_data);
          if (!in_tgt && idx >= 0) begin
            push_word(32'hF000_0000 + 32'(idx) * 8, 1);
            m_held = 0;
          end else begin
            push_word(m_h, 0);
            m_h = in_data;
          end
        end
      end else if (flush && m_held && slot_free) begin
        push_word(m_h, 0);
        m_held = 0;
      end
      if (wme) begin
        if (wr_sel) begin m_second[wr_idx] = WriteData; m_valid[wr_idx] = 1; end
        else        begin m_first[wr_idx]  = WriteData; m_valid[wr_idx] = 0; end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_oready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_pulse();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic dict_write(input int idx, input logic sel, input logic [W-1:0] d);
    wme = 1; wr_idx = 4'(idx); wr_sel = sel; WriteData = d;
    tick();
    wme = 0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic t);
    bit acc = 0;
    int n = 0;
    in_valid = 1; in_data = d; in_tgt = t;
    while (!acc) begin
      #1;
      acc = in_ready;
      tick();
      n++;
      if (!acc && n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout data=%h got=stalled exp=accepted", d);
        break;
      end
    end
    in_valid = 0; in_tgt = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic expect_got(input string name, input int i, input logic [W-1:0] d,
                            input logic [W-1:0] a);
    if (got_data.size() > i) begin
      chk({name, "_data"}, got_data[i], d);
      chk({name, "_addr"}, got_addr[i], a);
    end else begin
      chk({name, "_present"}, W'(got_data.size()), W'(i + 1));
    end
  endtask

  localparam logic [W-1:0] A = 32'h00A00093;
  localparam logic [W-1:0] B = 32'h00108113;
  localparam logic [W-1:0] C = 32'h00000013;

  initial begin
    logic [W-1:0] pool[6];
    int r;
    pool = '{A, B, C, 32'hF0000001, 32'h12345678, 32'h00208193};
    reset = 0; in_valid = 0; in_data = '0; in_tgt = 0; flush = 0; out_ready = 1;
    wme = 0; wr_idx = '0; wr_sel = 0; WriteData = '0;
    idle(2);
    reset = 1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), 32'd1);

    // pair compresses to a token
    reset_pulse();
    dict_write(2, 0, A); dict_write(2, 1, B);
    got_data.delete(); got_addr.delete();
    send(A, 0); send(B, 0); do_flush(); idle(3);
    chk("t1_count", W'(got_data.size()), 32'd1);
    expect_got("t1", 0, 32'hF0000010, 32'd0);
`ifdef CMP_STATS_EN
    chk("t1_tok_cnt", W'(tok_cnt), 32'd1);
`else
    chk("t1_tok_cnt", W'(tok_cnt), 32'd0);
`endif

    // branch target on second word blocks the pair
    reset_pulse();
    dict_write(2, 0, A); dict_write(2, 1, B);
    got_data.delete(); got_addr.delete();
    send(A, 0); send(B, 1); do_flush(); idle(3);
    chk("t2_count", W'(got_data.size()), 32'd2);
    expect_got("t2_0", 0, A, 32'd0);
    expect_got("t2_1", 1, B, 32'd4);

    // duplicate entries: lowest index wins
    reset_pulse();
    dict_write(5, 0, A); dict_write(5, 1, B);
    dict_write(1, 0, A); dict_write(1, 1, B);
    got_data.delete(); got_addr.delete();
    send(A, 0); send(B, 0); idle(3);
    expect_got("t3", 0, 32'hF0000008, 32'd0);

    // backpressure keeps output stable and loses nothing
    reset_pulse();
    got_data.delete(); got_addr.delete();
    out_ready = 0;
    send(32'h11, 0); send(32'h22, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_in_ready", W'(in_ready), '0);
      chk("t4_out_data", out_data, 32'h11);
      chk("t4_out_addr", out_addr, '0);
      tick();
    end
    out_ready = 1;
    send(32'h33, 0); do_flush(); idle(3);
    chk("t4_count", W'(got_data.size()), 32'd3);
    expect_got("t4_0", 0, 32'h11, 32'd0);
    expect_got("t4_1", 1, 32'h22, 32'd4);
    expect_got("t4_2", 2, 32'h33, 32'd8);

    // collide is sticky; reset mid-stream drops the held word and dictionary
    reset_pulse();
    dict_write(3, 0, A); dict_write(3, 1, B);
    got_data.delete(); got_addr.delete();
    send(32'hF1234567, 0); do_flush(); idle(2);
    expect_got("t5_raw", 0, 32'hF1234567, 32'd0);
    chk("t5_collide", W'(collide), 32'd1);
    idle(3);
    chk("t5_collide_sticky", W'(collide), 32'd1);
    send(A, 0);
    reset_pulse();
    chk("t5_rst_collide", W'(collide), '0);
    chk("t5_rst_valid", W'(out_valid), '0);
    chk("t5_rst_addr", out_addr, '0);
    got_data.delete(); got_addr.delete();
    do_flush(); idle(2);
    chk("t5_held_dropped", W'(got_data.size()), '0);
    send(A, 0); send(B, 0); do_flush(); idle(3);
    chk("t5_count", W'(got_data.size()), 32'd2);
    expect_got("t5_0", 0, A, 32'd0);

    // dictionary write racing a compare: old contents decide, new ones after
    reset_pulse();
    dict_write(0, 0, A); dict_write(0, 1, B);
    got_data.delete(); got_addr.delete();
    send(A, 0);
    wme = 1; wr_idx = 4'd0; wr_sel = 1; WriteData = C;
    send(B, 0);
    wme = 0;
    send(A, 0); send(B, 0); do_flush(); idle(3);
    chk("t6_count", W'(got_data.size()), 32'd3);
    expect_got("t6_0", 0, 32'hF0000000, 32'd0);
    expect_got("t6_1", 1, A, 32'd4);
    expect_got("t6_2", 2, B, 32'd8);

    // randomized traffic against the model
    reset_pulse();
    for (int i = 0; i < 16; i++) begin
      dict_write(i, 0, pool[$urandom_range(0, 5)]);
      if ($urandom_range(0, 3) != 0) dict_write(i, 1, pool[$urandom_range(0, 5)]);
    end
    rand_oready = 1;
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send(pool[$urandom_range(0, 5)], $urandom_range(0, 7) == 0);
      else if (r < 80) do_flush();
      else if (r < 88) dict_write($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                                  pool[$urandom_range(0, 5)]);
      else if (r < 98) tick();
      else             reset_pulse();
    end
    rand_oready = 0;
    out_ready = 1;
    do_flush(); idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_compressor.md
# instr_compressor

Offline/streaming instruction compressor: the encoder that produces the token stream consumed by the decompressor stage in front of the CPU. It accepts a stream of raw WIDTH-bit instructions and replaces each adjacent pair that matches an entry of a writable pair dictionary with a single token word. A token word carries the OPcode in its top bits and the dictionary byte address of the pair's first word; the second word sits at +PCADD. Raw words pass through unchanged. The block sits between the program loader and instruction memory; its dictionary contents mirror the decompressor's token table.

## Interface
- WIDTH, 32, instruction/data width
- PCADD, 32'b100, byte stride between words
- OPCODE, 4'b1111, token marker placed in the top ENCODE_LENGTH bits
- ENCODE_LENGTH, 4, token marker width
- ENTRIES, 16, dictionary pairs (power of two); IDX_W = log2(ENTRIES)

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  WIDTH  raw instruction
- in_tgt  in  1  word is a branch target (must not be second of a pair)
- flush  in  1  emit any held word raw
- out_valid  out  1  output word present
- out_ready  in  1  consumer takes word when out_valid && out_ready
- out_data  out  WIDTH  raw word or token
- out_addr  out  WIDTH  compressed-stream byte address of out_data
- wme  in  1  dictionary write enable
- wr_idx  in  IDX_W  dictionary entry
- wr_sel  in  1  0 = first word, 1 = second word
- WriteData  in  WIDTH  dictionary write data
- collide  out  1  sticky: a raw word had OPCODE in its top bits
- raw_cnt, tok_cnt  out  16 each  statistics (see Configuration)

## Operation
- Dictionary: ENTRIES × {first, second, valid}. Writing wr_sel=1 sets valid; writing wr_sel=0 clears valid. Reset clears all valid bits (data not reset).
- Token format: {OPCODE, zeros, idx, 3'b000}, i.e. low bits = idx*2*PCADD.
- States: EMPTY (no held word), HELD (one word in hold register H).
- EMPTY + accept word W → H=W, HELD; no output.
- HELD + accept W, W.in_tgt=0, (H,W) matches valid entry → emit token for lowest matching idx, EMPTY.
- HELD + accept W, no match or in_tgt=1 → emit H raw, H=W, stay HELD.
- HELD + flush with no accept → emit H raw, EMPTY. Flush and accept in the same cycle: accept rules apply, flush ignored. Flush in EMPTY: no effect.
- in_ready = !out_valid || out_ready. Output register held stable while out_valid && !out_ready.
- out_addr: counter starting at 0, advances by PCADD on each output handshake; wraps modulo 2^WIDTH.
- collide set when an emitted raw word has top ENCODE_LENGTH bits == OPCODE; word still emitted; cleared only by reset.
- Dictionary write in the same cycle as a match compare: compare uses pre-write contents.

## Timing
- Reset: state EMPTY, out_valid=0, out_data=0, out_addr=0, collide=0, raw_cnt=0, tok_cnt=0, in_ready=1.
- Output registered: word/token valid the cycle after the triggering accept or flush.
- Pair latency: token appears 1 cycle after the second word's handshake; raw word appears 1 cycle after the next word's handshake or flush.
- Dictionary write visible to compares on the following cycle.
- Throughput one input word per cycle with out_ready held high.

## Configuration
- CMP_STATS_EN defined: raw_cnt counts raw output handshakes, tok_cnt counts token output handshakes; both saturate at 16'hFFFF.
- Undefined: counters not built; raw_cnt and tok_cnt tied to 0.

## Test plan
- Load entry 2 = (0x00A00093, 0x00108113); stream 0x00A00093, 0x00108113, flush → single output 0xF0000010 at out_addr 0; tok_cnt=1.
- Same entry, stream 0x00A00093, 0x00108113 with in_tgt=1 on second, flush → outputs 0x00A00093 @0, 0x00108113 @4; no token.
- Entries 1 and 5 both equal (A,B); stream A,B → token 0xF0000008 (lowest idx).
- Hold out_ready=0 three cycles with output pending → out_data/out_addr stable, in_ready=0, no input lost; release → stream completes in order.
- Raw word 0xF1234567 passed → emitted unchanged, collide=1, stays 1 until reset; reset low mid-stream → all outputs return to reset values next edge, held word discarded, dictionary valid bits cleared.
- Write entry 0 second word in same cycle as matching pair arrives → old contents decide; repeat pair next → new contents decide.
